// File: rtl/pc_call_stack.sv
// Program counter with a hardware return-address stack for call/ret linkage.
// The stack is a circular buffer, so a call while full silently drops the oldest entry.
module pc_call_stack #(
    parameter int                 WIDTH     = 16,
    parameter int                 DEPTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    input  logic [WIDTH-1:0]           in,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pc_call_stack: DEPTH must be a power of 2 and at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_INC,
        ACT_LOAD,
        ACT_RET,
        ACT_CALL,
        ACT_RESET
    } act_e;

    act_e             act;
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_dec;
    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] mem [DEPTH];

    // One action per cycle, resolved by fixed priority.
    always_comb begin
        act = ACT_HOLD;
        if (reset)     act = ACT_RESET;
        else if (call) act = ACT_CALL;
        else if (ret)  act = ACT_RET;
        else if (load) act = ACT_LOAD;
        else if (inc)  act = ACT_INC;
    end

    assign out_inc = out + WIDTH'(1);
    assign top_dec = top - PW'(1);
    assign full    = (depth == DW'(DEPTH));
    assign empty   = (depth == '0);

    // top points at the next free slot; when full it also points at the oldest entry.
    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET: begin
                out       <= RESET_VEC;
                depth     <= '0;
                top       <= '0;
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            ACT_CALL: begin
                out <= in;
                top <= top + PW'(1);
                if (full) overflow <= 1'b1;
                else      depth    <= depth + DW'(1);
            end
            ACT_RET: begin
                if (empty) begin
                    underflow <= 1'b1;
                end else begin
                    out   <= mem[top_dec];
                    top   <= top_dec;
                    depth <= depth - DW'(1);
                end
            end
            ACT_LOAD: out <= in;
            ACT_INC:  out <= out_inc;
            default: ;
        endcase
    end

    // Storage needs no reset; depth alone says which entries are valid.
    always_ff @(posedge clk) begin
        if (act == ACT_CALL) mem[top] <= out_inc;
    end

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack with a queue-based reference model checked every cycle.
module tb_pc_call_stack;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0, load = 1'b0, inc = 1'b0, call = 1'b0, ret = 1'b0;
    logic [W-1:0] in = '0;
    logic [W-1:0] out;
    logic [2:0]   depth;
    logic         full, empty, overflow, underflow;

    pc_call_stack #(.WIDTH(W), .DEPTH(D), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .reset(reset), .load(load), .inc(inc), .call(call), .ret(ret),
        .in(in), .out(out), .depth(depth), .full(full), .empty(empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: a bounded LIFO of return addresses, oldest at the front.
    logic [W-1:0] m_out;
    logic [W-1:0] q[$];
    logic         m_ovf, m_unf;

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic rt,
                              input logic l, input logic i, input logic [W-1:0] d);
        logic [W-1:0] ra;
        if (r) begin
            m_out = 16'h0000;
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (c) begin
            if (q.size() == D) begin
                void'(q.pop_front());
                m_ovf = 1'b1;
            end
            ra = m_out + 16'd1;
            q.push_back(ra);
            m_out = d;
        end else if (rt) begin
            if (q.size() == 0) m_unf = 1'b1;
            else               m_out = q.pop_back();
        end else if (l) begin
            m_out = d;
        end else if (i) begin
            m_out = m_out + 16'd1;
        end
    endtask

    // Drive one cycle's controls, advance the model, and return just after the
    // following falling edge so outputs from that rising edge are stable.
    task automatic cyc(input logic r, input logic c, input logic rt,
                       input logic l, input logic i, input logic [W-1:0] d);
        reset = r; call = c; ret = rt; load = l; inc = i; in = d;
        model_step(r, c, rt, l, i, d);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out",       out,                   m_out);
            cmp("depth",     W'(depth),             W'(q.size()));
            cmp("full",      W'(full),              W'(q.size() == D));
            cmp("empty",     W'(empty),             W'(q.size() == 0));
            cmp("overflow",  W'(overflow),          W'(m_ovf));
            cmp("underflow", W'(underflow),         W'(m_unf));
        end
    end

    initial begin
        // reset wins over a simultaneous call
        cyc(1, 1, 0, 0, 0, 16'h1234);
        cmp("rst_out", out, 16'h0000);
        cmp("rst_depth", W'(depth), 16'd0);
        cmp("rst_empty", W'(empty), 16'd1);
        cmp("rst_flags", W'({full, overflow, underflow}), 16'd0);

        repeat (3) cyc(0, 0, 0, 0, 1, 16'h0000);
        cmp("inc3", out, 16'h0003);
        cyc(0, 0, 0, 1, 1, 16'h8285);
        cmp("load_over_inc", out, 16'h8285);
        cyc(0, 0, 0, 0, 0, 16'hFFFF);
        cmp("hold", out, 16'h8285);

        cyc(0, 0, 0, 1, 0, 16'h0010);
        cyc(0, 1, 0, 0, 0, 16'h0100);
        cmp("call_out", out, 16'h0100);
        cmp("call_depth", W'(depth), 16'd1);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        cmp("ret_out", out, 16'h0011);
        cmp("ret_empty", W'(empty), 16'd1);

        // call+ret together acts as call
        cyc(0, 1, 1, 0, 0, 16'h0300);
        cmp("callret_out", out, 16'h0300);
        cmp("callret_depth", W'(depth), 16'd1);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        cmp("callret_pop", out, 16'h0012);

        // overflow: five calls into a four-entry stack
        cyc(0, 0, 0, 1, 0, 16'h0000);
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 0, 0, 16'h000A + 16'(k));
        cmp("ovf_out", out, 16'h000E);
        cmp("ovf_depth", W'(depth), 16'd4);
        cmp("ovf_full", W'(full), 16'd1);
        cmp("ovf_flag", W'(overflow), 16'd1);
        begin
            logic [W-1:0] exp_pop [4];
            exp_pop = '{16'h000E, 16'h000D, 16'h000C, 16'h000B};
            for (int k = 0; k < 4; k++) begin
                cyc(0, 0, 1, 0, 0, 16'h0000);
                cmp("ovf_pop", out, exp_pop[k]);
            end
        end
        cyc(0, 0, 1, 0, 0, 16'h0000);
        cmp("unf_out", out, 16'h000B);
        cmp("unf_flag", W'(underflow), 16'd1);
        cmp("unf_empty", W'(empty), 16'd1);

        // wrap at 2^WIDTH for inc and for the pushed return address
        cyc(0, 0, 0, 1, 0, 16'hFFFF);
        cyc(0, 0, 0, 0, 1, 16'h0000);
        cmp("inc_wrap", out, 16'h0000);
        cyc(0, 0, 0, 1, 0, 16'hFFFF);
        cyc(0, 1, 0, 0, 0, 16'h0200);
        cmp("wrap_call", out, 16'h0200);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        cmp("wrap_ret", out, 16'h0000);

        // reset mid-stack, asserted with ret
        for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 0, 16'h0040 + 16'(k));
        cmp("pre_rst_depth", W'(depth), 16'd3);
        cyc(1, 0, 1, 0, 0, 16'h0000);
        cmp("midrst_out", out, 16'h0000);
        cmp("midrst_depth", W'(depth), 16'd0);
        cmp("midrst_flags", W'({overflow, underflow}), 16'd0);
        cyc(0, 0, 1, 0, 0, 16'h0000);
        cmp("post_rst_unf", W'(underflow), 16'd1);
        cmp("post_rst_out", out, 16'h0000);

        cyc(0, 0, 0, 0, 0, 16'h0000);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised successor to the Hack program counter: same reset/load/inc semantics, generalised width, plus a hardware return-address stack for call/return.
- Sits in the CPU fetch path. `out` drives instruction-memory address. The decoder asserts `call`/`ret` for subroutine linkage, so the CPU needs no software-managed link register.

Parameters:
- WIDTH, 16, PC and stack-entry width in bits.
- DEPTH, 8, return-stack entries; power of 2, at least 2.
- RESET_VEC, 0, value loaded into `out` on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; highest priority
- load  input  1  jump: out <= in
- inc  input  1  out <= out + 1
- call  input  1  push out+1, then out <= in
- ret  input  1  pop top of stack into out
- in  input  WIDTH  jump/call target
- out  output  WIDTH  registered program counter
- depth  output  $clog2(DEPTH+1)  number of valid stack entries (registered)
- full  output  1  depth == DEPTH (combinational from depth)
- empty  output  1  depth == 0 (combinational from depth)
- overflow  output  1  sticky: a call occurred while full
- underflow  output  1  sticky: a ret occurred while empty

Behaviour:
- All state updates on the rising edge of `clk`. `out`, `depth` and the flags are registered. A control sampled at edge N is visible just after edge N, with no extra latency.
- Reset values: out=RESET_VEC, depth=0, full=0, empty=1, overflow=0, underflow=0. Stack contents are don't-care after reset.
- Priority per cycle: reset > call > ret > load > inc > hold. Exactly one action is taken; lower-priority controls are ignored that cycle. In particular, call+ret together behaves as call, and load+inc behaves as load.
- Arithmetic: `out+1` is modulo 2^WIDTH, so 2^WIDTH-1 wraps to 0. This applies both to inc and to the pushed return address. `in` is treated as raw bits with no sign handling.
- call, not full: mem[top] <= out+1; depth += 1; out <= in.
- call, full: circular overwrite. The oldest entry is discarded and out+1 becomes the new top. Depth stays DEPTH, overflow <= 1, out <= in.
- ret, not empty: out <= top entry; depth -= 1.
- ret, empty: out holds; depth stays 0; underflow <= 1.
- After an overflow, successive rets return the DEPTH most recent return addresses in LIFO order, then underflow.
- Implementation: circular buffer with a log2(DEPTH)-bit top pointer (wraps) and a separate saturating depth counter. No read-during-write hazard exists, because push and pop never happen in the same cycle.
- overflow/underflow are sticky and are cleared only by reset.
- Reset mid-operation (including asserted together with call or ret) discards all stack entries and clears the flags. `out` becomes RESET_VEC; no push or pop takes effect.
- hold (no control asserted): all registers unchanged.

Test Plan (WIDTH=16, DEPTH=4, RESET_VEC=0):
- reset=1 for one edge with call=1, in=0x1234 -> out=0x0000, depth=0, empty=1, full=0, overflow=0, underflow=0.
- inc for 3 edges -> out=3. Then load=1, inc=1, in=0x8285 (-32123) -> out=0x8285. Then all controls low for one edge -> out holds 0x8285.
- load in=0x0010, then call in=0x0100 -> out=0x0100, depth=1. Then ret -> out=0x0011, depth=0, empty=1.
- From out=0, five calls with in=0x000A, 0x000B, 0x000C, 0x000D, 0x000E:
  - -> out=0x000E, depth=4, full=1, overflow=1.
  - Four rets -> out=0x000E, 0x000D, 0x000C, 0x000B; the entry 0x0001 was lost to overwrite.
  - Fifth ret -> out holds 0x000B, underflow=1, empty=1.
- load in=0xFFFF, then inc -> out=0x0000. Then load 0xFFFF, call in=0x0200, ret -> out=0x0000 (pushed value wrapped).
- Build depth=3, then assert reset with ret=1 -> out=0, depth=0, overflow=0, underflow=0. Next ret -> underflow=1, out=0.
